// File: rtl/seg_scan_595.sv
// Scans DIGITS multiplexed 7-segment digits through a 74HC595 chain as a
// 16-bit {seg, sel} word per digit. Optional leading-zero blanking: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_595 #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 4,
  parameter int HOLD           = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [8*DIGITS-1:0]   data,
  input  logic                  hex_mode,
  input  logic [DIGITS-1:0]     blank,
  output logic                  segled_clk,
  output logic                  segled_dat,
  output logic                  segled_str,
  output logic [2:0]            cur_digit,
  output logic                  frame_done
);

  // state     | meaning
  // ST_LOAD   | snapshot inputs of cur_digit into the shift word (1 cycle)
  // ST_SHIFT  | send 16 bits MSB first, CLK_DIV cycles per serial-clock phase
  // ST_STROBE | latch the 595 storage register for CLK_DIV cycles
  // ST_HOLD   | keep the digit lit for HOLD cycles, then advance cur_digit
  typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_STROBE, ST_HOLD} state_t;

  localparam int             CNT_MAX    = (HOLD > CLK_DIV) ? HOLD : CLK_DIV;
  localparam int             CW         = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  DIV_LD     = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  HOLD_LD    = CW'(HOLD - 1);
  localparam logic [2:0]     LAST_DIGIT = 3'(DIGITS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [2:0]    digit_q, digit_d;
  logic          sclk_q, sclk_d;
  logic          dat_q, dat_d;
  logic          str_q, str_d;
  logic          done_q, done_d;

  logic [DIGITS-1:0] lz_blank;
  logic [7:0]        cur_byte;
  logic              cur_blank;
  logic [7:0]        seg_w;
  logic [7:0]        sel_w;
  logic [15:0]       word;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk down from the top digit; the run of "0 without dp" stops at the first
  // digit that shows something. Digit 0 is outside the loop and always shown.
  always_comb begin
    lz_blank = '0;
    zero_run = hex_mode;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && ((data[8*i +: 8] & 8'h8F) == 8'h00);
      lz_blank[i] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    cur_byte  = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == 3'(i)) begin
        cur_byte  = data[8*i +: 8];
        cur_blank = blank[i] | lz_blank[i];
      end
    end
    seg_w = hex_mode ? {cur_byte[7], hex7(cur_byte[3:0])} : cur_byte;
    if (cur_blank) seg_w = 8'h00;
    sel_w = 8'b1 << digit_q;
    if (SEG_ACTIVE_LOW != 0) seg_w = ~seg_w;
    if (SEL_ACTIVE_LOW != 0) sel_w = ~sel_w;
    word = {seg_w, sel_w};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    digit_d = digit_q;
    sclk_d  = sclk_q;
    dat_d   = dat_q;
    case (state_q)
      ST_LOAD: begin
        shreg_d = word;
        dat_d   = word[15];
        sclk_d  = 1'b0;
        bit_d   = 4'd15;
        cnt_d   = DIV_LD;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = DIV_LD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge of the serial clock: present the next bit.
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              dat_d   = 1'b0;
              state_d = ST_STROBE;
            end else begin
              bit_d   = bit_q - 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
              dat_d   = shreg_q[14];
            end
          end
        end
      end
      ST_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d   = '0;
          digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    str_d  = (state_d == ST_STROBE);
    done_d = (state_d == ST_STROBE) && (cnt_d == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      digit_q <= '0;
      sclk_q  <= 1'b0;
      dat_q   <= 1'b0;
      str_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      digit_q <= digit_d;
      sclk_q  <= sclk_d;
      dat_q   <= dat_d;
      str_q   <= str_d;
      done_q  <= done_d;
    end
  end

  assign segled_clk = sclk_q;
  assign segled_dat = dat_q;
  assign segled_str = str_q;
  assign cur_digit  = digit_q;
  assign frame_done = done_q;

endmodule
